// File: rtl/lsb_in_pkg.sv
// Shared constants and register packing helpers for the button/switch input device.
package lsb_in_pkg;

    localparam int NUM_BTN = 4;
    localparam int NUM_SWI = 18;

    localparam logic ADDR_STATUS = 1'b0;
    localparam logic ADDR_EVT    = 1'b1;

    localparam int PRESS_LSB   = 0;
    localparam int RELEASE_LSB = 4;
    localparam int LONG_LSB    = 8;
    localparam int IE_LSB      = 16;
    localparam int IE_LOAD_BIT = 31;
    localparam int SWI_LSB     = 0;
    localparam int BTN_LSB     = 18;

    function automatic logic [31:0] pack_status(
        input logic [NUM_BTN-1:0] btn,
        input logic [NUM_SWI-1:0] swi
    );
        logic [31:0] word;
        word                      = '0;
        word[BTN_LSB +: NUM_BTN]  = btn;
        word[SWI_LSB +: NUM_SWI]  = swi;
        return word;
    endfunction

    function automatic logic [31:0] pack_evt(
        input logic [NUM_BTN-1:0] ie,
        input logic [NUM_BTN-1:0] long_evt,
        input logic [NUM_BTN-1:0] release_evt,
        input logic [NUM_BTN-1:0] press_evt
    );
        logic [31:0] word;
        word                          = '0;
        word[IE_LSB      +: NUM_BTN]  = ie;
        word[LONG_LSB    +: NUM_BTN]  = long_evt;
        word[RELEASE_LSB +: NUM_BTN]  = release_evt;
        word[PRESS_LSB   +: NUM_BTN]  = press_evt;
        return word;
    endfunction

endpackage

// File: rtl/lsb_in_deb_cell.sv
// One input channel: 2-FF synchroniser followed by a tick-sampled debounce counter.
module deb_cell #(
    parameter int DEB_SAMPLES = 8,
    parameter bit INVERT      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_SAMPLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          settle;
    logic [CW-1:0] cnt;

    // Synchroniser resets to the idle pin level so a held input is seen as a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= INVERT;
            sync2 <= INVERT;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign level  = sync2 ^ INVERT;
    assign settle = tick && (level != stable) && (cnt == CNT_LAST);
    assign rise   = settle && level;
    assign fall   = settle && !level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (tick) begin
            if (level != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= level;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/lsb_in_deb.sv
// Debounced DE2-115 buttons/switches with sticky press/release events and an irq.
// Optional long-press detection is built when LSB_LONG_PRESS_EN is defined.
module lsb_in_deb
    import lsb_in_pkg::*;
#(
    parameter int TICK_DIV    = 50000,
    parameter int DEB_SAMPLES = 8,
    parameter int LONG_TICKS  = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stb,
    input  logic        we,
    input  logic        addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    input  logic [3:0]  btn_in_n,
    input  logic [17:0] swi_in,
    output logic        irq
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam int LW = $clog2(LONG_TICKS + 1);
    localparam logic [LW-1:0] LONG_LIMIT = LW'(LONG_TICKS);

    logic [PW-1:0]      pre_cnt;
    logic               tick;
    logic [NUM_SWI-1:0] swi_stable;
    logic [NUM_BTN-1:0] btn_stable;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] btn_fall;
    logic [NUM_SWI-1:0] unused_swi_rise;
    logic [NUM_SWI-1:0] unused_swi_fall;

    logic               wr_evt;
    logic [NUM_BTN-1:0] w1c_press;
    logic [NUM_BTN-1:0] w1c_release;
    logic [NUM_BTN-1:0] press_evt;
    logic [NUM_BTN-1:0] release_evt;
    logic [NUM_BTN-1:0] long_evt;
    logic [NUM_BTN-1:0] ie;
    logic               unused_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign tick = (pre_cnt == PRE_LAST);

    for (genvar i = 0; i < NUM_SWI; i++) begin : g_swi
        deb_cell #(
            .DEB_SAMPLES (DEB_SAMPLES),
            .INVERT      (1'b0)
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .raw    (swi_in[i]),
            .stable (swi_stable[i]),
            .rise   (unused_swi_rise[i]),
            .fall   (unused_swi_fall[i])
        );
    end

    // Buttons are active-low on the board; the cell inverts so 1 means pressed.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        deb_cell #(
            .DEB_SAMPLES (DEB_SAMPLES),
            .INVERT      (1'b1)
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .raw    (btn_in_n[i]),
            .stable (btn_stable[i]),
            .rise   (btn_rise[i]),
            .fall   (btn_fall[i])
        );
    end

    assign wr_evt      = stb && we && (addr == ADDR_EVT);
    assign w1c_press   = wr_evt ? data_in[PRESS_LSB   +: NUM_BTN] : '0;
    assign w1c_release = wr_evt ? data_in[RELEASE_LSB +: NUM_BTN] : '0;

    // A clear and a new event on the same bit in one cycle keep the event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_evt   <= '0;
            release_evt <= '0;
            ie          <= '0;
        end else begin
            press_evt   <= (press_evt & ~w1c_press) | btn_rise;
            release_evt <= (release_evt & ~w1c_release) | btn_fall;
            if (wr_evt && data_in[IE_LOAD_BIT]) begin
                ie <= data_in[IE_LSB +: NUM_BTN];
            end
        end
    end

`ifdef LSB_LONG_PRESS_EN
    logic [NUM_BTN-1:0]         w1c_long;
    logic [NUM_BTN-1:0]         long_set;
    logic [NUM_BTN-1:0][LW-1:0] long_cnt;

    assign w1c_long = wr_evt ? data_in[LONG_LSB +: NUM_BTN] : '0;

    // Counter saturates so each press can flag at most one long event.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_long
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                long_cnt[i] <= '0;
            end else if (!btn_stable[i]) begin
                long_cnt[i] <= '0;
            end else if (tick && (long_cnt[i] != LONG_LIMIT)) begin
                long_cnt[i] <= long_cnt[i] + 1'b1;
            end
        end

        assign long_set[i] = tick && btn_stable[i] && (long_cnt[i] == LONG_LIMIT - 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_evt <= '0;
        end else begin
            long_evt <= (long_evt & ~w1c_long) | long_set;
        end
    end
`else
    logic unused_long;

    assign long_evt    = '0;
    assign unused_long = ^{data_in[LONG_LSB +: NUM_BTN], LONG_LIMIT};
`endif

    assign unused_data = ^{data_in[30:20], data_in[15:12]};

    assign ack = stb;
    assign irq = |(ie & (press_evt | long_evt));

    always_comb begin
        data_out = '0;
        if (stb && !we) begin
            if (addr == ADDR_STATUS) begin
                data_out = pack_status(btn_stable, swi_stable);
            end else begin
                data_out = pack_evt(ie, long_evt, release_evt, press_evt);
            end
        end
    end

endmodule
